// File: rtl/spi_flash_responder.sv
// spi_flash_responder: SPI mode-0 NOR flash read-subset emulator (READ, FAST READ, JEDEC ID, STATUS1).
// Revision 1.0 - initial release.
`default_nettype none
`timescale 1ns/1ps

module spi_flash_responder #(
  parameter int          ADDR_W   = 24,
  parameter logic [23:0] JEDEC_ID = 24'hEF4016,
  parameter logic [7:0]  STATUS1  = 8'h00
) (
  input  logic              MCLK,
  input  logic              RST,
  input  logic              nCS,
  input  logic              CLK,
  input  logic              MOSI,
  output logic              MISO,
  output logic              MISO_OE,
  output logic [ADDR_W-1:0] MEMADDR,
  output logic              MEMRD,
  input  logic [7:0]        MEMDATA,
  output logic              BUSY
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_ADDR   = 3'd2,
    S_DUMMY  = 3'd3,
    S_DATA   = 3'd4,
    S_ID     = 3'd5,
    S_STAT   = 3'd6,
    S_IGNORE = 3'd7
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [1:0]        ncs_sync_q, clk_sync_q, mosi_sync_q;
  logic              clk_prev_q;
  state_t            state_q, state_d;
  logic [4:0]        bitcnt_q, bitcnt_d;
  logic [7:0]        cmd_sh_q, cmd_sh_d;
  logic [23:0]       addr_sh_q, addr_sh_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              fast_q, fast_d;
  logic [1:0]        id_idx_q, id_idx_d;
  logic [7:0]        out_sh_q, out_sh_d;
  logic [7:0]        prefetch_q, prefetch_d;
  logic              miso_q, miso_d;
  logic              oe_q, oe_d;
  logic              memrd_q, memrd_d;
  logic [ADDR_W-1:0] memaddr_q, memaddr_d;
  logic              cap_q;
  logic              busy_q, busy_d;
  logic              armed_q, armed_d;

  logic              ncs_s, clk_s, mosi_s;
  logic              rise, fall;
  logic [7:0]        cmd_next;
  logic [23:0]       addr_next;
  logic [7:0]        resp_byte;

  assign ncs_s     = ncs_sync_q[1];
  assign clk_s     = clk_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];
  assign rise      = clk_s & ~clk_prev_q;
  assign fall      = ~clk_s & clk_prev_q;
  assign cmd_next  = {cmd_sh_q[6:0], mosi_s};
  assign addr_next = {addr_sh_q[22:0], mosi_s};

  always_comb begin
    resp_byte = STATUS1;
    case (state_q)
      S_DATA: resp_byte = prefetch_q;
      S_ID: begin
        case (id_idx_q)
          2'd0:    resp_byte = JEDEC_ID[23:16];
          2'd1:    resp_byte = JEDEC_ID[15:8];
          default: resp_byte = JEDEC_ID[7:0];
        endcase
      end
      default: resp_byte = STATUS1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    cmd_sh_d   = cmd_sh_q;
    addr_sh_d  = addr_sh_q;
    addr_d     = addr_q;
    fast_d     = fast_q;
    id_idx_d   = id_idx_q;
    out_sh_d   = out_sh_q;
    prefetch_d = cap_q ? MEMDATA : prefetch_q;
    miso_d     = miso_q;
    oe_d       = oe_q;
    memrd_d    = 1'b0;
    memaddr_d  = memaddr_q;
    busy_d     = busy_q;
    armed_d    = armed_q;

    // Deselect wins over any edge seen in the same cycle; no fetch or decode escapes.
    if (ncs_s) begin
      state_d  = S_IDLE;
      bitcnt_d = 5'd0;
      oe_d     = 1'b0;
      busy_d   = 1'b0;
      armed_d  = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (armed_q) begin
            state_d  = S_CMD;
            busy_d   = 1'b1;
            bitcnt_d = 5'd0;
            cmd_sh_d = 8'h00;
            id_idx_d = 2'd0;
          end
        end
        S_CMD: begin
          if (rise) begin
            cmd_sh_d = cmd_next;
            if (bitcnt_q == 5'd7) begin
              bitcnt_d = 5'd0;
              case (cmd_next)
                8'h03: begin state_d = S_ADDR; fast_d = 1'b0; end
                8'h0B: begin state_d = S_ADDR; fast_d = 1'b1; end
                8'h9F: state_d = S_ID;
                8'h05: state_d = S_STAT;
                default: state_d = S_IGNORE;
              endcase
            end else begin
              bitcnt_d = bitcnt_q + 5'd1;
            end
          end
        end
        S_ADDR: begin
          if (rise) begin
            addr_sh_d = addr_next;
            if (bitcnt_q == 5'd23) begin
              bitcnt_d = 5'd0;
              addr_d   = addr_next[ADDR_W-1:0];
              if (fast_q) begin
                state_d = S_DUMMY;
              end else begin
                state_d   = S_DATA;
                memrd_d   = 1'b1;
                memaddr_d = addr_next[ADDR_W-1:0];
              end
            end else begin
              bitcnt_d = bitcnt_q + 5'd1;
            end
          end
        end
        S_DUMMY: begin
          if (rise) begin
            if (bitcnt_q == 5'd7) begin
              bitcnt_d  = 5'd0;
              state_d   = S_DATA;
              memrd_d   = 1'b1;
              memaddr_d = addr_q;
            end else begin
              bitcnt_d = bitcnt_q + 5'd1;
            end
          end
        end
        S_DATA, S_ID, S_STAT: begin
          if (fall) begin
            if (bitcnt_q == 5'd0) begin
              out_sh_d = resp_byte;
              miso_d   = resp_byte[7];
              oe_d     = 1'b1;
              bitcnt_d = 5'd1;
              // addr_q tracks the byte being prefetched, so the next fetch is addr_q+1.
              if (state_q == S_DATA) begin
                addr_d    = addr_q + ADDR_ONE;
                memaddr_d = addr_q + ADDR_ONE;
                memrd_d   = 1'b1;
              end
              if (state_q == S_ID) begin
                id_idx_d = (id_idx_q == 2'd2) ? 2'd0 : id_idx_q + 2'd1;
              end
            end else begin
              out_sh_d = {out_sh_q[6:0], 1'b0};
              miso_d   = out_sh_q[6];
              bitcnt_d = (bitcnt_q == 5'd7) ? 5'd0 : bitcnt_q + 5'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge MCLK) begin
    if (RST) begin
      ncs_sync_q  <= 2'b00;
      clk_sync_q  <= 2'b00;
      mosi_sync_q <= 2'b00;
      clk_prev_q  <= 1'b0;
      state_q     <= S_IDLE;
      bitcnt_q    <= 5'd0;
      cmd_sh_q    <= 8'h00;
      addr_sh_q   <= 24'h0;
      addr_q      <= '0;
      fast_q      <= 1'b0;
      id_idx_q    <= 2'd0;
      out_sh_q    <= 8'h00;
      prefetch_q  <= 8'h00;
      miso_q      <= 1'b1;
      oe_q        <= 1'b0;
      memrd_q     <= 1'b0;
      memaddr_q   <= '0;
      cap_q       <= 1'b0;
      busy_q      <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      ncs_sync_q  <= {ncs_sync_q[0], nCS};
      clk_sync_q  <= {clk_sync_q[0], CLK};
      mosi_sync_q <= {mosi_sync_q[0], MOSI};
      clk_prev_q  <= clk_s;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      cmd_sh_q    <= cmd_sh_d;
      addr_sh_q   <= addr_sh_d;
      addr_q      <= addr_d;
      fast_q      <= fast_d;
      id_idx_q    <= id_idx_d;
      out_sh_q    <= out_sh_d;
      prefetch_q  <= prefetch_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      memrd_q     <= memrd_d;
      memaddr_q   <= memaddr_d;
      cap_q       <= memrd_q;
      busy_q      <= busy_d;
      armed_q     <= armed_d;
    end
  end

  assign MISO    = miso_q;
  assign MISO_OE = oe_q;
  assign MEMRD   = memrd_q;
  assign MEMADDR = memaddr_q;
  assign BUSY    = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: table of SPI transactions plus abort and reset sequences.
`default_nettype none
`timescale 1ns/1ps

module tb_spi_flash_responder;

  logic        MCLK, RST, nCS, CLK, MOSI;
  logic        MISO, MISO_OE, MEMRD, BUSY;
  logic [23:0] MEMADDR;
  logic [7:0]  MEMDATA;

  int checks = 0;
  int errors = 0;
  int memrd_cnt = 0;
  logic [23:0] fetch_q[$];

  spi_flash_responder #(.ADDR_W(24), .JEDEC_ID(24'hEF4016), .STATUS1(8'h00)) dut (
    .MCLK(MCLK), .RST(RST), .nCS(nCS), .CLK(CLK), .MOSI(MOSI),
    .MISO(MISO), .MISO_OE(MISO_OE), .MEMADDR(MEMADDR), .MEMRD(MEMRD),
    .MEMDATA(MEMDATA), .BUSY(BUSY)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  // Memory holds mem[n] = n[7:0], one-cycle read latency.
  always @(posedge MCLK) if (MEMRD) MEMDATA <= MEMADDR[7:0];

  always @(negedge MCLK) begin
    if (!RST && MEMRD) begin
      memrd_cnt = memrd_cnt + 1;
      fetch_q.push_back(MEMADDR);
    end
  end

  typedef struct {
    logic [7:0]  op;
    logic [23:0] addr;
    bit          has_addr;
    bit          dummy;
    int          nbytes;
    logic [31:0] exp;
    bit          exp_oe;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] rx,
                           output logic oe_and, output logic oe_or);
    oe_and = 1'b1;
    oe_or  = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      MOSI = tx[i];
      repeat (8) @(negedge MCLK);
      CLK = 1'b1;
      rx[i]  = MISO;
      oe_and = oe_and & MISO_OE;
      oe_or  = oe_or | MISO_OE;
      repeat (8) @(negedge MCLK);
      CLK = 1'b0;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [7:0] rx;
    logic       oa, oo;
    int         base_cnt, base_q;
    logic [23:0] ea;
    base_cnt = memrd_cnt;
    base_q   = fetch_q.size();
    nCS = 1'b0;
    repeat (6) @(negedge MCLK);
    chk($sformatf("v%0d busy", idx), {31'd0, BUSY}, 32'd1);
    xfer_byte(v.op, rx, oa, oo);
    if (v.has_addr) begin
      xfer_byte(v.addr[23:16], rx, oa, oo);
      xfer_byte(v.addr[15:8], rx, oa, oo);
      xfer_byte(v.addr[7:0], rx, oa, oo);
      chk($sformatf("v%0d fetch_before_resp", idx), {31'd0, memrd_cnt != base_cnt}, {31'd0, !v.dummy});
      if (v.dummy) begin
        xfer_byte(8'hFF, rx, oa, oo);
        chk($sformatf("v%0d fetch_after_dummy", idx), {31'd0, memrd_cnt != base_cnt}, 32'd1);
      end
    end
    for (int b = 0; b < v.nbytes; b++) begin
      xfer_byte(8'hFF, rx, oa, oo);
      chk($sformatf("v%0d b%0d oe", idx, b), {30'd0, oa, oo}, {30'd0, v.exp_oe, v.exp_oe});
      if (v.exp_oe)
        chk($sformatf("v%0d b%0d data", idx, b), {24'd0, rx}, {24'd0, v.exp[31-8*b -: 8]});
    end
    repeat (8) @(negedge MCLK);
    nCS = 1'b1;
    repeat (6) @(negedge MCLK);
    chk($sformatf("v%0d deselect", idx), {30'd0, MISO_OE, BUSY}, 32'd0);
    if (v.has_addr) begin
      chk($sformatf("v%0d fetch_count", idx), {31'd0, fetch_q.size() - base_q >= v.nbytes}, 32'd1);
      for (int b = 0; b < v.nbytes && base_q + b < fetch_q.size(); b++) begin
        ea = v.addr + 24'(b);
        chk($sformatf("v%0d fetch_addr%0d", idx, b), {8'd0, fetch_q[base_q + b]}, {8'd0, ea});
      end
    end else begin
      chk($sformatf("v%0d no_fetch", idx), memrd_cnt - base_cnt, 32'd0);
    end
  endtask

  initial begin
    logic [7:0] rx;
    logic       oa, oo;
    vecs[0] = '{8'h03, 24'h0003FA, 1'b1, 1'b0, 4, 32'hFAFBFCFD, 1'b1};
    vecs[1] = '{8'h0B, 24'h000010, 1'b1, 1'b1, 2, 32'h10110000, 1'b1};
    vecs[2] = '{8'h9F, 24'h000000, 1'b0, 1'b0, 4, 32'hEF4016EF, 1'b1};
    vecs[3] = '{8'h05, 24'h000000, 1'b0, 1'b0, 2, 32'h00000000, 1'b1};
    vecs[4] = '{8'hA5, 24'h000000, 1'b0, 1'b0, 2, 32'h00000000, 1'b0};
    vecs[5] = '{8'h03, 24'hFFFFFE, 1'b1, 1'b0, 3, 32'hFEFF0000, 1'b1};

    RST = 1'b1; nCS = 1'b1; CLK = 1'b0; MOSI = 1'b0;
    repeat (5) @(negedge MCLK);
    chk("reset outputs", {4'd0, MISO, MISO_OE, MEMRD, BUSY, MEMADDR}, {4'd0, 4'b1000, 24'h0});
    RST = 1'b0;
    repeat (100) @(negedge MCLK);
    chk("idle outputs", {29'd0, MISO_OE, BUSY, MEMRD}, 32'd0);
    chk("idle memrd count", memrd_cnt, 32'd0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Abort a READ four bits into the second data byte.
    nCS = 1'b0;
    repeat (6) @(negedge MCLK);
    xfer_byte(8'h03, rx, oa, oo);
    xfer_byte(8'h00, rx, oa, oo);
    xfer_byte(8'h01, rx, oa, oo);
    xfer_byte(8'h00, rx, oa, oo);
    xfer_byte(8'hFF, rx, oa, oo);
    chk("abort first byte", {24'd0, rx}, 32'h00);
    for (int i = 0; i < 4; i++) begin
      MOSI = 1'b1;
      repeat (8) @(negedge MCLK);
      CLK = 1'b1;
      repeat (8) @(negedge MCLK);
      CLK = 1'b0;
    end
    repeat (4) @(negedge MCLK);
    chk("abort oe before", {31'd0, MISO_OE}, 32'd1);
    nCS = 1'b1;
    repeat (3) @(negedge MCLK);
    chk("abort oe/busy within 3", {30'd0, MISO_OE, BUSY}, 32'd0);
    repeat (8) @(negedge MCLK);
    run_vec(vecs[3], 6);

    // Reset with nCS low mid-command: no decode until nCS has been high.
    nCS = 1'b0;
    repeat (6) @(negedge MCLK);
    for (int i = 0; i < 3; i++) begin
      MOSI = 1'b0;
      repeat (8) @(negedge MCLK);
      CLK = 1'b1;
      repeat (8) @(negedge MCLK);
      CLK = 1'b0;
    end
    RST = 1'b1;
    repeat (3) @(negedge MCLK);
    RST = 1'b0;
    repeat (6) @(negedge MCLK);
    xfer_byte(8'h05, rx, oa, oo);
    xfer_byte(8'hFF, rx, oa, oo);
    chk("rearm oe stays low", {31'd0, oo}, 32'd0);
    chk("rearm busy low", {31'd0, BUSY}, 32'd0);
    nCS = 1'b1;
    repeat (8) @(negedge MCLK);
    run_vec(vecs[3], 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
- Synthesizable SPI-mode-0 serial NOR flash responder that emulates the W25Q32-class read subset consumed by the SPI loader.
- Lets bubble image data stored in on-chip/SDRAM-backed memory be served to an SPI master in emulation and in loopback benches, with no external flash part.
- All SPI pins are oversampled in the MCLK domain; memory is read through a 1-cycle-latency synchronous byte port.

Parameters:
- ADDR_W, 24, flash byte address width; address counter wraps modulo 2^ADDR_W.
- JEDEC_ID, 24'hEF4016, 3 bytes returned by 9Fh, MSB first.
- STATUS1, 8'h00, byte returned repeatedly by 05h.

Ports:
- MCLK  in  1  system clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- nCS  in  1  SPI chip select, active low, asynchronous to MCLK
- CLK  in  1  SPI serial clock, asynchronous to MCLK, idle low (mode 0)
- MOSI  in  1  SPI data from master
- MISO  out  1  SPI data to master
- MISO_OE  out  1  MISO output enable; top level tri-states MISO when 0
- MEMADDR  out  ADDR_W  byte address to memory
- MEMRD  out  1  one-cycle read strobe
- MEMDATA  in  8  byte valid exactly 1 MCLK after MEMRD
- BUSY  out  1  high while a transaction is selected (synced nCS low)

Behaviour:
- Reset: MISO=1, MISO_OE=0, MEMRD=0, MEMADDR=0, BUSY=0, state=IDLE, all counters and shift registers 0.
- Synchronization:
  - nCS, CLK and MOSI each pass through a 2-flop synchronizer of equal depth.
  - Rise = synced CLK 0->1; fall = synced CLK 1->0.
  - Required SPI timing: CLK high and low phases each >= 6 MCLK; nCS setup/hold to the first/last CLK edge >= 4 MCLK.
- Deselect:
  - Synced nCS high forces state=IDLE, bit counter=0, MISO_OE=0, BUSY=0 on the next MCLK.
  - Deselect overrides any simultaneous edge and aborts a transaction mid-byte with no side effect.
- Sampling and driving:
  - MOSI is sampled on rise, MSB first.
  - MISO changes only on fall.
  - MISO_OE rises on the fall that drives the first response bit.
- States:
  - IDLE: enter CMD when synced nCS goes low.
  - CMD: shift 8 bits. On the 8th rise decode:
    - 03h -> ADDR (READ)
    - 0Bh -> ADDR (FAST)
    - 9Fh -> ID
    - 05h -> STAT
    - anything else -> IGNORE
  - ADDR: shift 24 bits; keep only the low ADDR_W bits. On the 24th rise: READ -> DATA with a fetch issued; FAST -> DUMMY.
  - DUMMY: count 8 rises, then go to DATA with a fetch issued on the 8th rise.
  - DATA:
    - A fetch drives MEMADDR=addr and pulses MEMRD for 1 cycle on the MCLK after the triggering rise.
    - MEMDATA is captured into a prefetch register on the following cycle.
    - On each byte-boundary fall (bit counter=0), the prefetch register loads the output shift register, bit7 goes to MISO, addr increments, and the next fetch is issued.
    - Subsequent falls shift out bits 6..0.
    - Address wraps from 2^ADDR_W-1 to 0.
    - Streaming is unbounded until deselect.
  - ID: on byte-boundary falls, output JEDEC_ID[23:16], [15:8], [7:0], then repeat the sequence.
  - STAT: output STATUS1 on every byte.
  - IGNORE: MISO_OE stays 0; all edges are ignored until deselect.
- MOSI during response states (DATA, ID, STAT, DUMMY) is ignored.
- Reset asserted mid-transaction returns to the reset values. The responder then waits for nCS to be high before re-arming, so a partially clocked transaction is never decoded.

Test Plan:
- Reset then idle: nCS held high for 100 MCLK -> MISO_OE=0, MEMRD never pulses, BUSY=0.
- READ: memory[n]=n[7:0]; master sends 03h, addr 0003FAh (1018), clocks 4 bytes -> MISO bytes FAh, FBh, FCh, FDh. MEMRD pulses with MEMADDR 3FAh..3FDh; the first pulse occurs before the first response fall.
- FAST READ: 0Bh, addr 000010h, 8 dummy clocks, 2 bytes -> 10h, 11h. No MEMRD pulse before the 8th dummy rise.
- JEDEC: 9Fh then 4 bytes -> EFh, 40h, 16h, EFh. Unknown opcode A5h then 2 bytes -> MISO_OE stays 0.
- Wrap/abort:
  - READ at FFFFFEh for 3 bytes with ADDR_W=24 -> bytes from FFFFFEh, FFFFFFh, 000000h.
  - Separately, raise nCS after bit 3 of a byte -> MISO_OE=0 within 3 MCLK. A following 05h transaction returns 00h correctly.
